sram_1rw_port_ctrl: RTL and testbench
=====================================

// Module: sram_1rw_port_ctrl
// PURPOSE
//  Initiator for the single-port 1rw SRAM macro interface (DATA inout, ADDR, CSb, WEb, OEb, clk).
//  - Converts a valid/ready request stream (read/write) into SRAM pin sequencing.
//  - Owns the bidirectional data bus and captures read data into a valid/ready response.
//  - Sits between the bank arbiter and one SRAM bank instance.
// PARAMETERS
//  DATA_WIDTH      32  SRAM word width.
//  ADDR_WIDTH      9   SRAM address width.
//  RD_WAIT_CYCLES  1   Cycles after the SRAM read edge before the data capture edge; legal range 1..15.
// PORTS
//  clk          in     1           Clock. Shared with the SRAM clk.
//  rstb         in     1           Asynchronous reset, active low.
//  req_valid    in     1           Request valid.
//  req_ready    out    1           Request accepted when valid&&ready at the clk rising edge.
//  req_we       in     1           1 = write, 0 = read.
//  req_addr     in     ADDR_WIDTH  Word address.
//  req_wdata    in     DATA_WIDTH  Write data.
//  rsp_valid    out    1           Read data valid.
//  rsp_ready    in     1           Response consumer ready.
//  rsp_rdata    out    DATA_WIDTH  Captured read data.
//  sram_csb     out    1           SRAM chip select, active low.
//  sram_web     out    1           SRAM write enable, active low.
//  sram_oeb     out    1           SRAM output enable, active low.
//  sram_addr    out    ADDR_WIDTH  SRAM address.
//  sram_data    inout  DATA_WIDTH  SRAM data bus. Driven only in WR; Z otherwise.
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset rstb is asynchronous and active low.
//  All sram_* controls and rsp_* outputs are registered.
//  Reset values (also forced on rstb assertion mid-operation; the in-flight op is dropped):
//   - state=IDLE, sram_csb=1, sram_web=1, sram_oeb=1, sram_addr=0, bus Z.
//   - rsp_valid=0, rsp_rdata=0, wait counter=0.
//   - req_ready = (state==IDLE), so it reads 1 after reset.
//  States:
//   - IDLE: req_ready=1; all SRAM controls inactive.
//     On accept: latch addr and wdata; go to WR if req_we, else RD.
//   - WR (1 cycle): csb=0, web=0, oeb=1; drive sram_data=wdata.
//     SRAM writes at the cycle-ending edge. Next state: IDLE. Writes produce no response.
//   - RD (1 cycle): csb=0, web=1, oeb=0, addr held. SRAM samples at the cycle-ending edge.
//     Load counter=RD_WAIT_CYCLES-1. Next state: WAIT.
//   - WAIT: csb=0, web=1, oeb=0 held; re-reading the same address is harmless.
//     Decrement the counter each cycle. On the edge where counter==0:
//     capture sram_data into rsp_rdata, set rsp_valid=1, deassert csb/oeb, go to RSP.
//   - RSP: rsp_valid=1 and rsp_rdata stable until rsp_valid&&rsp_ready.
//     Then rsp_valid=0 and go to IDLE (or TA, see CONFIGURATION).
//  Latency:
//   - Write: accept at edge E0; SRAM write at E1; req_ready high again after E1.
//     Throughput is 1 write per 2 cycles.
//   - Read: accept at E0; rsp_valid rises after E(1+RD_WAIT_CYCLES); default is 2 edges.
//  Boundary conditions:
//   - No new request is accepted while a response is pending (one op in flight).
//   - rsp_ready held high in RSP: the response completes in exactly one cycle.
//   - Address 2^ADDR_WIDTH-1 has no wrap or special case.
//  Bus rules:
//   - The controller's data output enable is asserted only when registered web==0.
//   - oeb is never 0 in the same cycle as web==0.
//   - X on sram_data at the capture edge is propagated to rsp_rdata unchanged (not masked).
// CONFIGURATION
//  SRAM_CTRL_TURNAROUND_EN:
//   - Defined: after every read response handshake, the FSM spends exactly one cycle in TA.
//     In TA: req_ready=0, all SRAM controls inactive, bus Z. Then IDLE.
//     This guarantees one dead cycle between SRAM drive and controller drive.
//   - Undefined: TA does not exist; RSP goes directly to IDLE.
// TESTING
//  1. Reset: rstb=0 mid-read (in WAIT)
//     -> next cycle csb=1, web=1, oeb=1, rsp_valid=0, bus Z.
//     -> after release, req_ready=1.
//  2. Write 0xDEADBEEF @0x005, then read 0x005
//     -> rsp_rdata=0xDEADBEEF, rsp_valid 2 edges after read accept.
//  3. Back-to-back writes @0x000..0x003 with req_valid held high
//     -> accepts on every 2nd edge; 4 SRAM write strobes (csb=0, web=0).
//  4. Read @0x1FF with rsp_ready=0 for 5 cycles
//     -> rsp_valid and rsp_rdata stable 5 cycles; req_ready=0 throughout.
//  5. RD_WAIT_CYCLES=3: read @0x010 holding 0x12345678
//     -> rsp_valid rises 4 edges after accept, data correct.
//  6. SRAM_CTRL_TURNAROUND_EN: read then write queued
//     -> exactly 1 cycle with bus Z and csb=1 between the rsp handshake and req_ready=1.
//     -> never web=0 while oeb=0.

Source files
------------

// File: rtl/sram_1rw_port_ctrl.sv
// Single-port 1rw SRAM initiator: request stream to CSb/WEb/OEb pin sequencing, registered read response.
// Optional: define SRAM_CTRL_TURNAROUND_EN to add one dead bus cycle (TA) after every read response.
module sram_1rw_port_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 9,
   parameter int RD_WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  sram_csb,
   output logic                  sram_web,
   output logic                  sram_oeb,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   inout  wire  [DATA_WIDTH-1:0] sram_data
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR   = 3'd1,
      S_RD   = 3'd2,
      S_WAIT = 3'd3,
      S_RSP  = 3'd4
`ifdef SRAM_CTRL_TURNAROUND_EN
      , S_TA = 3'd5
`endif
   } state_t;

   // Counter starts at RD_WAIT_CYCLES-1 so capture happens RD_WAIT_CYCLES edges after the read edge.
   localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT_CYCLES - 1);

   state_t                 state_q, state_d;
   logic                   csb_d, web_d, oeb_d;
   logic [3:0]             wait_cnt_q;
   logic [DATA_WIDTH-1:0]  wdata_q;
   logic                   accept;

   assign req_ready = (state_q == S_IDLE);
   assign accept    = req_valid && req_ready;

   // Drive enable follows the registered web, so the bus is only driven during the WR cycle.
   assign sram_data = sram_web ? {DATA_WIDTH{1'bz}} : wdata_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q  <= S_IDLE;
         sram_csb <= 1'b1;
         sram_web <= 1'b1;
         sram_oeb <= 1'b1;
      end else begin
         state_q  <= state_d;
         sram_csb <= csb_d;
         sram_web <= web_d;
         sram_oeb <= oeb_d;
      end
   end

   // NOTE: every combinational output gets a default first, otherwise unlisted paths infer latches.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (req_valid) state_d = req_we ? S_WR : S_RD;
         S_WR:   state_d = S_IDLE;
         S_RD:   state_d = S_WAIT;
         S_WAIT: if (wait_cnt_q == 4'd0) state_d = S_RSP;
         S_RSP: begin
            if (rsp_ready) begin
`ifdef SRAM_CTRL_TURNAROUND_EN
               state_d = S_TA;
`else
               state_d = S_IDLE;
`endif
            end
         end
`ifdef SRAM_CTRL_TURNAROUND_EN
         S_TA:   state_d = S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Pin values are decoded from the next state so they are registered alongside it.
   always_comb begin
      csb_d = 1'b1;
      web_d = 1'b1;
      oeb_d = 1'b1;
      case (state_d)
         S_WR: begin
            csb_d = 1'b0;
            web_d = 1'b0;
         end
         S_RD, S_WAIT: begin
            csb_d = 1'b0;
            oeb_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         sram_addr  <= '0;
         wdata_q    <= '0;
         wait_cnt_q <= 4'd0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         if (accept) begin
            sram_addr <= req_addr;
            wdata_q   <= req_wdata;
         end

         if (state_q == S_RD)
            wait_cnt_q <= WAIT_LOAD;
         else if (state_q == S_WAIT && wait_cnt_q != 4'd0)
            wait_cnt_q <= wait_cnt_q - 4'd1;

         // Bus value is captured as-is, including any X the macro presents.
         if (state_q == S_WAIT && wait_cnt_q == 4'd0) begin
            rsp_rdata <= sram_data;
            rsp_valid <= 1'b1;
         end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sram_1rw_port_ctrl.sv
// Bench for sram_1rw_port_ctrl: two instances (RD_WAIT_CYCLES 1 and 3), each with a behavioural SRAM,
// checked against a transaction-level memory model. Honours SRAM_CTRL_TURNAROUND_EN when defined.
module tb_sram_1rw_port_ctrl;

   localparam int DW = 32;
   localparam int AW = 9;
   localparam int NP = 2;
   localparam int DEPTH = 2 ** AW;

   logic          clk = 1'b0;
   logic          rstb;
   logic          req_valid [NP];
   logic          req_we    [NP];
   logic          rsp_ready [NP];
   logic [AW-1:0] req_addr  [NP];
   logic [DW-1:0] req_wdata [NP];
   logic          req_ready [NP];
   logic          rsp_valid [NP];
   logic [DW-1:0] rsp_rdata [NP];
   logic          sram_csb  [NP];
   logic          sram_web  [NP];
   logic          sram_oeb  [NP];
   logic [AW-1:0] sram_addr [NP];

   logic [DW-1:0] ref_mem [NP][DEPTH];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   function automatic int rdw(input int p);
      return (p == 0) ? 1 : 3;
   endfunction

   function automatic logic [DW-1:0] init_word(input int a);
      return DW'(a * 32'h9E37_79B1 + 32'h0000_1234);
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   for (genvar g = 0; g < NP; g++) begin : g_port
      wire  [DW-1:0] bus;
      logic [DW-1:0] mem [DEPTH];
      logic [DW-1:0] rd_q;

      sram_1rw_port_ctrl #(
         .DATA_WIDTH    (DW),
         .ADDR_WIDTH    (AW),
         .RD_WAIT_CYCLES(g == 0 ? 1 : 3)
      ) u_dut (
         .clk       (clk),
         .rstb      (rstb),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_we    (req_we[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_rdata (rsp_rdata[g]),
         .sram_csb  (sram_csb[g]),
         .sram_web  (sram_web[g]),
         .sram_oeb  (sram_oeb[g]),
         .sram_addr (sram_addr[g]),
         .sram_data (bus)
      );

      // Behavioural macro: write on the edge when csb/web low, register read data on a read edge.
      assign bus = (!sram_csb[g] && !sram_oeb[g]) ? rd_q : {DW{1'bz}};

      initial begin
         for (int a = 0; a < DEPTH; a++) mem[a] = init_word(a);
      end

      always @(posedge clk) begin
         if (!sram_csb[g] && !sram_web[g]) mem[sram_addr[g]] <= bus;
         if (!sram_csb[g] &&  sram_web[g]) rd_q <= mem[sram_addr[g]];
      end
   end

   // Bus-rule invariant: the macro output enable and write enable are never active together.
   always @(negedge clk) begin
      if (rstb) begin
         for (int p = 0; p < NP; p++)
            check($sformatf("web_oeb_overlap_p%0d", p), {63'd0, !sram_web[p] && !sram_oeb[p]}, 64'd0);
      end
   end

   task automatic do_req(input int p, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input int hold);
      int n;
      n = 0;
      while (!req_ready[p] && n < 20) begin
         tick();
         n++;
      end
      check("req_ready_before_req", req_ready[p], 1);
      req_valid[p] = 1'b1;
      req_we[p]    = we;
      req_addr[p]  = addr;
      req_wdata[p] = data;
      rsp_ready[p] = 1'b0;
      tick();
      req_valid[p] = 1'b0;
      check("busy_after_accept", req_ready[p], 0);
      check("sram_addr", sram_addr[p], addr);
      if (we) begin
         check("wr_pins_csb_web_oeb", {sram_csb[p], sram_web[p], sram_oeb[p]}, 3'b001);
         ref_mem[p][addr] = data;
         tick();
         check("wr_ready_again", req_ready[p], 1);
         check("wr_done_pins", {sram_csb[p], sram_web[p], sram_oeb[p]}, 3'b111);
      end else begin
         check("rd_pins_csb_web_oeb", {sram_csb[p], sram_web[p], sram_oeb[p]}, 3'b010);
         n = 0;
         while (!rsp_valid[p] && n < 40) begin
            tick();
            n++;
            check("rd_no_accept", req_ready[p], 0);
         end
         check("rd_latency_edges", n, 1 + rdw(p));
         check("rd_data", rsp_rdata[p], ref_mem[p][addr]);
         check("rsp_pins_idle", {sram_csb[p], sram_web[p], sram_oeb[p]}, 3'b111);
         for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", rsp_valid[p], 1);
            check("hold_data", rsp_rdata[p], ref_mem[p][addr]);
            check("hold_no_accept", req_ready[p], 0);
         end
         rsp_ready[p] = 1'b1;
         tick();
         rsp_ready[p] = 1'b0;
         check("rsp_valid_dropped", rsp_valid[p], 0);
`ifdef SRAM_CTRL_TURNAROUND_EN
         check("ta_not_ready", req_ready[p], 0);
         check("ta_pins_csb_web", {sram_csb[p], sram_web[p]}, 2'b11);
         tick();
`endif
         check("ready_after_rsp", req_ready[p], 1);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int            accepts, strobes, cyc, last;
      bit            acc;
      logic [AW-1:0] a;
      logic [DW-1:0] d;

      for (int p = 0; p < NP; p++) begin
         req_valid[p] = 1'b0;
         req_we[p]    = 1'b0;
         rsp_ready[p] = 1'b0;
         req_addr[p]  = '0;
         req_wdata[p] = '0;
         for (int i = 0; i < DEPTH; i++) ref_mem[p][i] = init_word(i);
      end
      rstb = 1'b0;
      tick();
      tick();
      for (int p = 0; p < NP; p++) begin
         check("reset_pins", {sram_csb[p], sram_web[p], sram_oeb[p]}, 3'b111);
         check("reset_rsp_valid", rsp_valid[p], 0);
         check("reset_rsp_rdata", rsp_rdata[p], 0);
         check("reset_sram_addr", sram_addr[p], 0);
      end
      rstb = 1'b1;
      tick();
      check("ready_after_reset", req_ready[0], 1);

      // Write then read back a known word with the default wait.
      do_req(0, 1'b1, 9'h005, 32'hDEAD_BEEF, 0);
      do_req(0, 1'b0, 9'h005, '0, 0);

      // Back-to-back writes with req_valid held high.
      accepts = 0; strobes = 0; cyc = 0; last = 0;
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b1;
      req_addr[0]  = '0;
      req_wdata[0] = $urandom;
      while (accepts < 4 && cyc < 40) begin
         acc = req_ready[0];
         tick();
         cyc++;
         if (!sram_csb[0] && !sram_web[0]) strobes++;
         if (acc) begin
            ref_mem[0][req_addr[0]] = req_wdata[0];
            if (accepts > 0) check("b2b_accept_spacing", cyc - last, 2);
            last = cyc;
            accepts++;
            req_addr[0]  = req_addr[0] + 9'd1;
            req_wdata[0] = $urandom;
         end
      end
      req_valid[0] = 1'b0;
      tick();
      if (!sram_csb[0] && !sram_web[0]) strobes++;
      check("b2b_accepts", accepts, 4);
      check("b2b_write_strobes", strobes, 4);
      for (int i = 0; i < 4; i++) do_req(0, 1'b0, AW'(i), '0, 0);

      // Top address, response held back for 5 cycles.
      do_req(0, 1'b1, 9'h1FF, 32'hA5A5_0FF0, 0);
      do_req(0, 1'b0, 9'h1FF, '0, 5);

      // Longer read wait on the second instance.
      do_req(1, 1'b1, 9'h010, 32'h1234_5678, 0);
      do_req(1, 1'b0, 9'h010, '0, 0);

      // Reset asserted while the read is in its wait phase.
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b0;
      req_addr[1]  = 9'h020;
      tick();
      req_valid[1] = 1'b0;
      tick();
      check("pre_reset_wait_pins", {sram_csb[1], sram_web[1], sram_oeb[1]}, 3'b010);
      rstb = 1'b0;
      #1;
      check("async_reset_pins", {sram_csb[1], sram_web[1], sram_oeb[1]}, 3'b111);
      tick();
      check("reset_mid_read_pins", {sram_csb[1], sram_web[1], sram_oeb[1]}, 3'b111);
      check("reset_mid_read_rsp_valid", rsp_valid[1], 0);
      check("reset_mid_read_addr", sram_addr[1], 0);
      rstb = 1'b1;
      tick();
      check("ready_after_mid_reset", req_ready[1], 1);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("dropped_read_no_rsp", rsp_valid[1], 0);
      end

      // Randomised traffic on both instances.
      for (int p = 0; p < NP; p++) begin
         for (int k = 0; k < 30; k++) begin
            a = ($urandom_range(0, 7) == 0) ? {AW{1'b1}} : AW'($urandom_range(0, 15));
            d = $urandom;
            do_req(p, 1'($urandom_range(0, 1)), a, d, $urandom_range(0, 3));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
